id_ex_pipe_reg: RTL
===================

// Module: id_ex_pipe_reg
// PURPOSE
//  Parametrised ID->EX pipeline register with valid/ready handshake, flush and bubble insertion.
//  Sits between decode and execute and carries inst, PC, operands and the rd write request.
//  Successor to the fixed 32-bit free-running stage register: adds backpressure, flush,
//  and an optional skid buffer.
// PARAMETERS
//  XLEN        32            data/address width of inst, inst_addr, rs1/rs2 data
//  RADDR_W     5             register-file address width (rd_addr)
//  NOP_INST    32'h00000013  instruction word driven on inst_o for bubbles (addi x0,x0,0)
// PORTS
//  clk            in   1        clock, all state on rising edge
//  rst            in   1        synchronous reset, active-high
//  flush_i        in   1        kill stage contents (branch/jump redirect from EX)
//  in_valid_i     in   1        ID presents a valid instruction
//  in_ready_o     out  1        stage can accept this cycle
//  inst_i         in   XLEN     instruction word
//  inst_addr_i    in   XLEN     instruction PC
//  rs1_data_i     in   XLEN     rs1 operand
//  rs2_data_i     in   XLEN     rs2 operand
//  rd_addr_i      in   RADDR_W  destination register
//  rd_wen_i       in   1        destination write enable
//  out_valid_o    out  1        EX holds a valid instruction
//  out_ready_i    in   1        EX consumes the instruction this cycle
//  inst_o, inst_addr_o, rs1_data_o, rs2_data_o  out  XLEN  registered copies
//  rd_addr_o      out  RADDR_W  registered rd
//  rd_wen_o       out  1        registered write enable, forced 0 when out_valid_o=0
// BEHAVIOUR
//  - Reset (rst=1 at edge): out_valid_o=0, rd_wen_o=0, rd_addr_o=0, inst_o=NOP_INST,
//    inst_addr_o/rs1_data_o/rs2_data_o=0; skid (if present) empty. Reset mid-transfer drops it.
//  - Accept: in_valid_i & in_ready_o. Drain: out_valid_o & out_ready_i.
//  - Output register loads when (~out_valid_o | out_ready_i); loaded value = input (or skid
//    entry, see CONFIGURATION); out_valid_o <= accepted source valid. Latency 1 cycle.
//  - If output register is not loadable, all *_o hold their value (stall).
//  - Bubble: when loading with no valid source, out_valid_o<=0, rd_wen_o<=0, inst_o<=NOP_INST;
//    other data outputs are don't-care (implementation holds them).
//  - Invariant: rd_wen_o=1 only if out_valid_o=1.
//  - flush_i has priority over load/accept: next cycle out_valid_o=0, rd_wen_o=0,
//    inst_o=NOP_INST, skid emptied; input offered in the flush cycle is discarded even if
//    in_ready_o was 1 (ID is flushed in the same cycle by the hazard unit).
//  - rst has priority over flush_i.
//  - No state machine beyond output-valid and skid-valid bits.
// CONFIGURATION
//  ID_EX_SKID_EN undefined: in_ready_o = ~out_valid_o | out_ready_i (combinational path
//    from out_ready_i); no skid storage.
//  ID_EX_SKID_EN defined: 1-entry skid buffer; in_ready_o = ~skid_valid (registered, no
//    comb path from out_ready_i). Accept while output stalled -> entry goes to skid.
//    When output loadable: source is skid if skid_valid else input; skid drains to output
//    and input simultaneously accepted goes to skid only if output remains stalled, else
//    input is accepted next cycle (in_ready_o rises after drain). Ordering strictly FIFO.
// TESTING
//  1 rst=1 2 cycles -> out_valid_o=0, rd_wen_o=0, inst_o=32'h00000013, others 0.
//  2 in_valid=1 inst=32'h00500093 pc=32'h100 rd=1 wen=1, out_ready=1 -> next cycle
//    out_valid=1, inst_o=32'h00500093, inst_addr_o=32'h100, rd_wen_o=1; back-to-back 4 instrs
//    stream with 1 instr/cycle throughput.
//  3 out_ready=0 for 3 cycles with valid output -> outputs frozen; non-skid in_ready_o=0;
//    skid build: first input held in skid, in_ready_o=0, released in order after out_ready=1.
//  4 flush_i=1 with valid output and in_valid=1 -> next cycle out_valid=0, rd_wen_o=0,
//    inst_o=NOP, flushed input never appears on outputs.
//  5 in_valid=0 with out_ready=1 -> bubble: out_valid=0, rd_wen_o=0 regardless of rd_wen_i=1.
//  6 random valid/ready/flush 10k cycles vs scoreboard -> no loss/dup/reorder, wen invariant.

Source files
------------

// File: rtl/id_ex_pipe_reg.sv
// ID->EX pipeline register with valid/ready handshake, flush and NOP bubble insertion.
// Define ID_EX_SKID_EN to add a 1-entry skid buffer that registers in_ready_o.
module id_ex_pipe_reg #(
    parameter int              XLEN     = 32,
    parameter int              RADDR_W  = 5,
    parameter logic [XLEN-1:0] NOP_INST = 32'h00000013
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               flush_i,
    input  logic               in_valid_i,
    output logic               in_ready_o,
    input  logic [XLEN-1:0]    inst_i,
    input  logic [XLEN-1:0]    inst_addr_i,
    input  logic [XLEN-1:0]    rs1_data_i,
    input  logic [XLEN-1:0]    rs2_data_i,
    input  logic [RADDR_W-1:0] rd_addr_i,
    input  logic               rd_wen_i,
    output logic               out_valid_o,
    input  logic               out_ready_i,
    output logic [XLEN-1:0]    inst_o,
    output logic [XLEN-1:0]    inst_addr_o,
    output logic [XLEN-1:0]    rs1_data_o,
    output logic [XLEN-1:0]    rs2_data_o,
    output logic [RADDR_W-1:0] rd_addr_o,
    output logic               rd_wen_o
);

    localparam int PW = 4 * XLEN + RADDR_W + 1;

    logic               out_valid;
    logic               load;
    logic               src_valid;
    logic [PW-1:0]      in_payload;
    logic [PW-1:0]      src_payload;
    logic [XLEN-1:0]    src_inst;
    logic [XLEN-1:0]    src_addr;
    logic [XLEN-1:0]    src_rs1;
    logic [XLEN-1:0]    src_rs2;
    logic [RADDR_W-1:0] src_rd;
    logic               src_wen;

    assign load        = ~out_valid | out_ready_i;
    assign in_payload  = {inst_i, inst_addr_i, rs1_data_i, rs2_data_i, rd_addr_i, rd_wen_i};
    assign {src_inst, src_addr, src_rs1, src_rs2, src_rd, src_wen} = src_payload;
    assign out_valid_o = out_valid;

`ifdef ID_EX_SKID_EN
    logic          skid_valid;
    logic [PW-1:0] skid_data;

    // While the skid holds an entry it is the older one, so it always feeds the output first.
    assign in_ready_o  = ~skid_valid;
    assign src_valid   = skid_valid | in_valid_i;
    assign src_payload = skid_valid ? skid_data : in_payload;

    always_ff @(posedge clk) begin
        if (rst) begin
            skid_valid <= 1'b0;
            skid_data  <= '0;
        end else if (flush_i) begin
            skid_valid <= 1'b0;
        end else if (skid_valid) begin
            if (load) begin
                skid_valid <= 1'b0;
            end
        end else if (in_valid_i && !load) begin
            skid_valid <= 1'b1;
            skid_data  <= in_payload;
        end
    end
`else
    assign in_ready_o  = load;
    assign src_valid   = in_valid_i;
    assign src_payload = in_payload;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid   <= 1'b0;
            inst_o      <= NOP_INST;
            inst_addr_o <= '0;
            rs1_data_o  <= '0;
            rs2_data_o  <= '0;
            rd_addr_o   <= '0;
            rd_wen_o    <= 1'b0;
        end else if (flush_i) begin
            out_valid <= 1'b0;
            inst_o    <= NOP_INST;
            rd_wen_o  <= 1'b0;
        end else if (load) begin
            if (src_valid) begin
                out_valid   <= 1'b1;
                inst_o      <= src_inst;
                inst_addr_o <= src_addr;
                rs1_data_o  <= src_rs1;
                rs2_data_o  <= src_rs2;
                rd_addr_o   <= src_rd;
                rd_wen_o    <= src_wen;
            end else begin
                // Bubble: the operand fields keep stale values, only the control side is cleared.
                out_valid <= 1'b0;
                inst_o    <= NOP_INST;
                rd_wen_o  <= 1'b0;
            end
        end
    end

endmodule
